// File: rtl/ram_bit_loader.sv
// ram_bit_loader
//   Packs a serial bit stream LSB-first into WORD_W-bit words and writes each
//   finished word through port A of a dual-port RAM. Serial bit k ends up at
//   word k/WORD_W, bit k%WORD_W. Port B can then read the RAM one bit per
//   address.
//
// Ports
//   clk_in     in   clock, all logic on the rising edge
//   rst        in   asynchronous reset, active low
//   start      in   pulse: clear pointers and flags, begin a new load frame
//   bit_in     in   serial data bit
//   bit_valid  in   bit_in is valid this cycle
//   bit_last   in   marks bit_in as the final bit of the frame
//   bit_ready  out  loader accepts a bit this cycle (FILL state only)
//   ena, wea   out  port-A enable / write enable, one-cycle strobe per word
//   addra      out  port-A word address (holds the last written address)
//   dina       out  port-A write data (holds the last written word)
//   bit_count  out  bits accepted in the current frame, saturating
//   done       out  frame complete (last bit seen or RAM full)
//   overflow   out  sticky: a bit was offered while done was high
module ram_bit_loader #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              bit_last,
  output logic              bit_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [WORD_W-1:0] dina,
  output logic [12:0]       bit_count,
  output logic              done,
  output logic              overflow
);

  localparam int POS_W = $clog2(WORD_W);
  localparam logic [12:0]       COUNT_MAX = 13'(DEPTH * WORD_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   assembly_q, assembly_d;
  logic [POS_W-1:0]    bitpos_q, bitpos_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [12:0]         count_q, count_d;
  logic                ena_q, ena_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [WORD_W-1:0]   dina_q, dina_d;
  logic                overflow_q, overflow_d;

  logic [WORD_W-1:0]   word_with_bit;
  logic                word_done;

  // The incoming bit merged into the partial word; this is what gets written
  // when the bit completes the word, so no extra cycle is spent on assembly.
  assign word_with_bit = assembly_q | (WORD_W'(bit_in) << bitpos_q);
  assign word_done     = (bitpos_q == LAST_POS) || bit_last;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      assembly_q <= '0;
      bitpos_q   <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      ena_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      assembly_q <= assembly_d;
      bitpos_q   <= bitpos_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      ena_q      <= ena_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    assembly_d = assembly_q;
    bitpos_d   = bitpos_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    ena_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;
    overflow_d = overflow_q;

    if (start) begin
      // start beats any same-cycle bit; a word completing in this cycle is
      // therefore never written. A strobe already high still finishes.
      state_d    = S_FILL;
      assembly_d = '0;
      bitpos_d   = '0;
      ptr_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (bit_valid) begin
            count_d = (count_q == COUNT_MAX) ? count_q : count_q + 13'd1;
            if (word_done) begin
              ena_d      = 1'b1;
              addra_d    = ptr_q;
              dina_d     = word_with_bit;
              assembly_d = '0;
              bitpos_d   = '0;
              if (bit_last || (ptr_q == LAST_ADDR)) begin
                state_d = S_DONE;
              end
              // Pointer stops at the last word so it cannot wrap in a frame.
              if (ptr_q != LAST_ADDR) begin
                ptr_d = ptr_q + 1'b1;
              end
            end else begin
              assembly_d = word_with_bit;
              bitpos_d   = bitpos_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bit_valid) begin
            overflow_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bit_ready = (state_q == S_FILL);
  assign done      = (state_q == S_DONE);
  assign ena       = ena_q;
  assign wea       = ena_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign bit_count = count_q;
  assign overflow  = overflow_q;

endmodule
